// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_unit
// Purpose  : ID-stage hazard controller for the 5-stage pipeline.
//            - load-use and branch-in-ID data hazard detection
//              (stall PC/IF-ID, bubble into ID/EX)
//            - taken-branch squash of IF/ID
//            - branch comparator forwarding select (MEM ALU result / WB)
//            - registered memory-wait FSM that freezes the whole pipe while
//              the data memory is slow, with a sticky timeout error
// Ports    : clk, rst                       clock / sync active-high reset
//            id_*                           ID-stage instruction fields
//            ex_*, mem_*, wb_*              downstream destination info
//            mem_req, mem_ready             data-memory handshake
//            stall, id_flush, if_flush      pipeline control
//            freeze                         hold every pipeline register
//            fwd_a, fwd_b                   comparator operand select
//                                           (00 regfile, 01 MEM, 10 WB)
//            mem_err                        sticky memory-timeout flag
//            cnt_lu, cnt_br, cnt_frz        hazard statistics (optional)
// Config   : define HAZARD_STATS_EN to add the saturating statistics
//            counters and their output ports.
// Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl_unit #(
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              id_branch,
  input  logic              id_br_taken,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_regwrite,
  input  logic              mem_memtoreg,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_req,
  input  logic              mem_ready,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  output logic              stall,
  output logic              id_flush,
  output logic              if_flush,
  output logic              freeze,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mem_err
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0]  cnt_lu,
  output logic [CNT_W-1:0]  cnt_br,
  output logic [CNT_W-1:0]  cnt_frz
`endif
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int WCNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  localparam logic [WCNT_W-1:0] C_TIMEOUT = WCNT_W'(MEM_TIMEOUT);
  localparam logic [WCNT_W-1:0] C_WCNT_ONE = WCNT_W'(1);

  localparam logic [1:0] C_ST_RUN  = 2'd0;
  localparam logic [1:0] C_ST_WAIT = 2'd1;
  localparam logic [1:0] C_ST_ERR  = 2'd2;

  localparam logic [1:0] C_FWD_RF  = 2'b00;
  localparam logic [1:0] C_FWD_MEM = 2'b01;
  localparam logic [1:0] C_FWD_WB  = 2'b10;

  // Register 0 is hard-wired zero, so it never matches anything.
  function automatic logic reg_match(input logic [REG_AW-1:0] x,
                                     input logic [REG_AW-1:0] r);
    return (x != '0) && (x == r);
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]        state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q,  wcnt_d;

  // --------------------------------------------------------------------------
  // Hazard detection
  // --------------------------------------------------------------------------
  logic w_lu;
  logic w_br_ex;
  logic w_br_ld;
  logic w_hazard;
  logic w_miss;
  logic w_freeze;
  logic w_stall;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  always_comb begin
    w_lu    = ex_memread &&
              (reg_match(ex_rd, id_rs) || (id_uses_rt && reg_match(ex_rd, id_rt)));
    // A branch compares in ID, so an ALU result still in EX cannot be
    // forwarded in time; neither can load data still in MEM.
    w_br_ex = id_branch && ex_regwrite &&
              (reg_match(ex_rd, id_rs) || reg_match(ex_rd, id_rt));
    w_br_ld = id_branch && mem_regwrite && mem_memtoreg &&
              (reg_match(mem_rd, id_rs) || reg_match(mem_rd, id_rt));
    w_hazard = w_lu || w_br_ex || w_br_ld;

    // Freeze starts combinationally in the very cycle the miss is seen.
    w_miss   = (state_q == C_ST_RUN) && mem_req && !mem_ready;
    w_freeze = w_miss || (state_q == C_ST_WAIT) || (state_q == C_ST_ERR);
    w_stall  = w_hazard && !w_freeze;

    // MEM ALU result is newer than WB, so it wins.
    w_fwd_a = C_FWD_RF;
    if (id_branch && mem_regwrite && !mem_memtoreg && reg_match(mem_rd, id_rs))
      w_fwd_a = C_FWD_MEM;
    else if (id_branch && wb_regwrite && reg_match(wb_rd, id_rs))
      w_fwd_a = C_FWD_WB;

    w_fwd_b = C_FWD_RF;
    if (id_branch && mem_regwrite && !mem_memtoreg && reg_match(mem_rd, id_rt))
      w_fwd_b = C_FWD_MEM;
    else if (id_branch && wb_regwrite && reg_match(wb_rd, id_rt))
      w_fwd_b = C_FWD_WB;
  end

  // --------------------------------------------------------------------------
  // Memory-wait FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      C_ST_RUN: begin
        if (mem_req && !mem_ready) begin
          state_d = C_ST_WAIT;
          wcnt_d  = C_WCNT_ONE;
        end
      end
      C_ST_WAIT: begin
        if (mem_ready) begin
          state_d = C_ST_RUN;
          wcnt_d  = '0;
        end else if (wcnt_q == C_TIMEOUT) begin
          state_d = C_ST_ERR;
        end else begin
          wcnt_d = wcnt_q + C_WCNT_ONE;
        end
      end
      C_ST_ERR: begin
        state_d = C_ST_ERR;  // only reset leaves the error state
      end
      default: begin
        state_d = C_ST_RUN;
        wcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= C_ST_RUN;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: freeze > data stall > branch flush; all quiet during reset.
  // --------------------------------------------------------------------------
  always_comb begin
    stall    = 1'b0;
    id_flush = 1'b0;
    if_flush = 1'b0;
    freeze   = 1'b0;
    fwd_a    = C_FWD_RF;
    fwd_b    = C_FWD_RF;
    mem_err  = 1'b0;
    if (!rst) begin
      freeze   = w_freeze;
      stall    = w_stall;
      id_flush = w_stall;
      if_flush = id_branch && id_br_taken && !w_stall && !w_freeze;
      mem_err  = (state_q == C_ST_ERR);
      // The branch is not resolved this cycle, so the select is irrelevant.
      if (!w_stall && !w_freeze) begin
        fwd_a = w_fwd_a;
        fwd_b = w_fwd_b;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  // --------------------------------------------------------------------------
  // Saturating hazard statistics
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_lu_q,  cnt_lu_d;
  logic [CNT_W-1:0] cnt_br_q,  cnt_br_d;
  logic [CNT_W-1:0] cnt_frz_q, cnt_frz_d;

  always_comb begin
    cnt_lu_d  = cnt_lu_q;
    cnt_br_d  = cnt_br_q;
    cnt_frz_d = cnt_frz_q;
    if (w_stall && w_lu && (cnt_lu_q != '1))
      cnt_lu_d = cnt_lu_q + CNT_W'(1);
    if (w_stall && !w_lu && (cnt_br_q != '1))
      cnt_br_d = cnt_br_q + CNT_W'(1);
    if (w_freeze && (cnt_frz_q != '1))
      cnt_frz_d = cnt_frz_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_lu_q  <= '0;
      cnt_br_q  <= '0;
      cnt_frz_q <= '0;
    end else begin
      cnt_lu_q  <= cnt_lu_d;
      cnt_br_q  <= cnt_br_d;
      cnt_frz_q <= cnt_frz_d;
    end
  end

  assign cnt_lu  = rst ? '0 : cnt_lu_q;
  assign cnt_br  = rst ? '0 : cnt_br_q;
  assign cnt_frz = rst ? '0 : cnt_frz_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl_unit
// Purpose  : Self-checking bench for hazard_ctrl_unit: directed scenarios
//            followed by randomized traffic, every cycle compared against a
//            behavioural model of the hazard rules and the memory wait.
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl_unit;

  localparam int AW = 5;
  localparam int TO = 4;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
  logic          id_uses_rt, id_branch, id_br_taken;
  logic          ex_regwrite, ex_memread;
  logic          mem_regwrite, mem_memtoreg, mem_req, mem_ready;
  logic          wb_regwrite;
  logic          stall, id_flush, if_flush, freeze, mem_err;
  logic [1:0]    fwd_a, fwd_b;
`ifdef HAZARD_STATS_EN
  logic [CW-1:0] cnt_lu, cnt_br, cnt_frz;
`endif

  hazard_ctrl_unit #(.REG_AW(AW), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_branch(id_branch), .id_br_taken(id_br_taken),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg), .mem_rd(mem_rd),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .stall(stall), .id_flush(id_flush), .if_flush(if_flush), .freeze(freeze),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err)
`ifdef HAZARD_STATS_EN
    , .cnt_lu(cnt_lu), .cnt_br(cnt_br), .cnt_frz(cnt_frz)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Model state: number of cycles the current access has already waited
  // (0 = no access outstanding) and the sticky timeout flag.
  int m_waited = 0;
  bit m_err    = 1'b0;
  int m_lu = 0, m_br = 0, m_frz = 0;

  // Expected outputs for the current cycle.
  bit       e_stall, e_ifl, e_frz, e_err, e_lu_stall;
  bit [1:0] e_fa, e_fb;

  function automatic bit hit(input logic [AW-1:0] x, input logic [AW-1:0] r);
    return (x != 0) && (x == r);
  endfunction

  function automatic bit [1:0] fwd_sel(input logic [AW-1:0] src);
    if (!id_branch) return 2'b00;
    if (mem_regwrite && !mem_memtoreg && hit(mem_rd, src)) return 2'b01;
    if (wb_regwrite && hit(wb_rd, src)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic predict();
    bit lu, bre, brl, hz;
    lu  = ex_memread && (hit(ex_rd, id_rs) || (id_uses_rt && hit(ex_rd, id_rt)));
    bre = id_branch && ex_regwrite && (hit(ex_rd, id_rs) || hit(ex_rd, id_rt));
    brl = id_branch && mem_regwrite && mem_memtoreg && (hit(mem_rd, id_rs) || hit(mem_rd, id_rt));
    hz  = lu || bre || brl;
    e_frz      = m_err || (m_waited > 0) || (mem_req && !mem_ready);
    e_stall    = hz && !e_frz;
    e_lu_stall = e_stall && lu;
    e_ifl      = id_branch && id_br_taken && !e_stall && !e_frz;
    e_err      = m_err;
    e_fa       = (e_stall || e_frz) ? 2'b00 : fwd_sel(id_rs);
    e_fb       = (e_stall || e_frz) ? 2'b00 : fwd_sel(id_rt);
    if (rst) begin
      {e_stall, e_ifl, e_frz, e_err, e_lu_stall} = '0;
      e_fa = 2'b00;
      e_fb = 2'b00;
    end
  endtask

  // Let the inputs settle and compare every output against the model.
  task automatic settle();
    #1;
    predict();
    check("stall",    stall,    e_stall);
    check("id_flush", id_flush, e_stall);
    check("if_flush", if_flush, e_ifl);
    check("freeze",   freeze,   e_frz);
    check("fwd_a",    fwd_a,    e_fa);
    check("fwd_b",    fwd_b,    e_fb);
    check("mem_err",  mem_err,  e_err);
`ifdef HAZARD_STATS_EN
    check("cnt_lu",  cnt_lu,  rst ? 16'd0 : 16'(m_lu));
    check("cnt_br",  cnt_br,  rst ? 16'd0 : 16'(m_br));
    check("cnt_frz", cnt_frz, rst ? 16'd0 : 16'(m_frz));
`endif
  endtask

  // Clock edge: advance the model with the inputs present at the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_waited = 0; m_err = 1'b0; m_lu = 0; m_br = 0; m_frz = 0;
    end else begin
      if (e_lu_stall) m_lu++;
      if (e_stall && !e_lu_stall) m_br++;
      if (e_frz) m_frz++;
      if (!m_err) begin
        if (m_waited > 0) begin
          if (mem_ready)          m_waited = 0;
          else if (m_waited == TO) m_err = 1'b1;
          else                     m_waited++;
        end else if (mem_req && !mem_ready) begin
          m_waited = 1;
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    rst = 0; id_rs = 0; id_rt = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
    id_uses_rt = 0; id_branch = 0; id_br_taken = 0;
    ex_regwrite = 0; ex_memread = 0;
    mem_regwrite = 0; mem_memtoreg = 0; mem_req = 0; mem_ready = 0;
    wb_regwrite = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    @(posedge clk); #1;
    // Reset with hazard-producing inputs: everything must stay low.
    ex_memread = 1; ex_rd = 8; id_rs = 8; id_branch = 1; id_br_taken = 1;
    settle();
    check("rst_stall", stall, 1'b0);
    check("rst_ifl", if_flush, 1'b0);
    tick();

    // T1: load-use on rs, then rt not read -> no stall
    idle(); ex_memread = 1; ex_rd = 8; id_rs = 8;
    settle(); check("t1_stall", stall, 1'b1); check("t1_idfl", id_flush, 1'b1); tick();
    idle(); ex_memread = 1; ex_rd = 8; id_rt = 8; id_rs = 3; id_uses_rt = 0;
    settle(); check("t1_no_rt", stall, 1'b0); tick();

    // T2: branch on EX ALU result stalls, next cycle forwards from MEM
    idle(); id_branch = 1; ex_regwrite = 1; ex_rd = 5; id_rt = 5;
    settle(); check("t2_stall", stall, 1'b1); tick();
    idle(); id_branch = 1; mem_regwrite = 1; mem_rd = 5; id_rt = 5;
    settle(); check("t2_nostall", stall, 1'b0); check("t2_fwd_b", fwd_b, 2'b01); tick();

    // T3: branch on load in MEM stalls, then WB forward, rd=0 never hazards
    idle(); id_branch = 1; mem_regwrite = 1; mem_memtoreg = 1; mem_rd = 9; id_rs = 9;
    settle(); check("t3_stall", stall, 1'b1); tick();
    idle(); id_branch = 1; wb_regwrite = 1; wb_rd = 9; id_rs = 9;
    settle(); check("t3_fwd_a", fwd_a, 2'b10); tick();
    idle(); id_branch = 1; ex_regwrite = 1; ex_memread = 1; ex_rd = 0;
    mem_regwrite = 1; mem_memtoreg = 1; mem_rd = 0; id_uses_rt = 1;
    settle(); check("t3_zero", stall, 1'b0); tick();

    // T4: three-cycle miss with a concurrent load-use hazard
    for (int i = 0; i < 3; i++) begin
      idle(); mem_req = 1; ex_memread = 1; ex_rd = 4; id_rs = 4;
      settle(); check("t4_freeze", freeze, 1'b1); check("t4_stall", stall, 1'b0); tick();
    end
    idle(); mem_req = 1; mem_ready = 1; settle(); tick();
    idle(); settle(); check("t4_run", freeze, 1'b0); tick();

    // T5: timeout with MEM_TIMEOUT=4: five freeze cycles then sticky error
    for (int i = 0; i < 5; i++) begin
      idle(); mem_req = 1;
      settle(); check("t5_frz", freeze, 1'b1); check("t5_noerr", mem_err, 1'b0); tick();
    end
    for (int i = 0; i < 3; i++) begin
      idle(); mem_ready = (i == 1);
      settle(); check("t5_err", mem_err, 1'b1); check("t5_frz_err", freeze, 1'b1); tick();
    end
    idle(); rst = 1; id_branch = 1; id_br_taken = 1;
    settle(); check("t5_rst_err", mem_err, 1'b0); check("t5_rst_frz", freeze, 1'b0); tick();
    idle(); settle(); check("t5_after", freeze, 1'b0); tick();

    // T6: taken branch flushes unless a hazard stalls it
    idle(); id_branch = 1; id_br_taken = 1; id_rs = 2; id_rt = 3;
    settle(); check("t6_flush", if_flush, 1'b1); tick();
    idle(); id_branch = 1; id_br_taken = 1; id_rs = 2; ex_memread = 1; ex_rd = 2;
    settle(); check("t6_noflush", if_flush, 1'b0); check("t6_stall", stall, 1'b1); tick();

    // Randomized traffic; small register range to provoke collisions.
    for (int n = 0; n < 800; n++) begin
      rst          = ($urandom_range(0, 40) == 0);
      id_rs        = AW'($urandom_range(0, 3));
      id_rt        = AW'($urandom_range(0, 3));
      ex_rd        = AW'($urandom_range(0, 3));
      mem_rd       = AW'($urandom_range(0, 3));
      wb_rd        = AW'($urandom_range(0, 3));
      id_uses_rt   = 1'($urandom);
      id_branch    = 1'($urandom);
      id_br_taken  = 1'($urandom);
      ex_regwrite  = 1'($urandom);
      ex_memread   = 1'($urandom);
      mem_regwrite = 1'($urandom);
      mem_memtoreg = 1'($urandom);
      wb_regwrite  = 1'($urandom);
      mem_req      = ($urandom_range(0, 3) == 0);
      mem_ready    = 1'($urandom);
      settle();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
